if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode/control unit.
- Owns the PC and runs a request/ready handshake to instruction memory.
- Honours decode stall and flush, and applies branch/jump redirects resolved in decode (no delay slot).
- Delivers instrD/pcD/pcPlus4D/validD to decode, which extracts opD/functD from instrD.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word presented when IF/ID holds a bubble

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
stallD  in  1  decode cannot accept; hold IF/ID
flushD  in  1  squash IF/ID contents next edge
pcSrcD  in  1  branch taken, redirect to pcBranchD
pcBranchD  in  32  branch target
jumpD  in  1  jump, redirect to pcJumpD
pcJumpD  in  32  jump target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pcF)
imem_rdy  in  1  imem_rdata valid this cycle; may be combinational on req
imem_rdata  in  32  instruction word
instrD  out  32  IF/ID instruction
pcD  out  32  IF/ID PC
pcPlus4D  out  32  IF/ID PC+4
validD  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=0, async):
  - pcF=RESET_PC, state=FETCH.
  - instrD=NOP_INSTR, pcD=0, pcPlus4D=0, validD=0, skid buffer invalid.
  - imem_req forced 0 while rst=0.
  - Reset mid-handshake abandons the outstanding request; the memory side must tolerate this.
- Handshake:
  - imem_req=1 only in FETCH and DRAIN.
  - imem_addr stays stable while req=1 and rdy=0.
  - A transfer completes on any edge where req=1 and rdy=1.
- Redirect: redir = jumpD | pcSrcD; target = jumpD ? pcJumpD : pcBranchD (jump wins if both).
- States:
  - FETCH:
    - rdy=1, no redir, stallD=0: deliver imem_rdata to IF/ID; pcF<=pcF+4; stay FETCH.
    - rdy=1, no redir, stallD=1: capture imem_rdata and pcF into skid; pcF<=pcF+4; go HOLD.
    - rdy=1, redir: discard data; pcF<=target; stay FETCH.
    - rdy=0, redir: latch target into pendPC; go DRAIN.
    - rdy=0, no redir: wait.
  - HOLD:
    - req=0.
    - redir: drop skid; pcF<=target; go FETCH.
    - else when stallD=0: move skid into IF/ID; go FETCH.
  - DRAIN:
    - req=1 at the old pcF.
    - Further redirects overwrite pendPC.
    - On rdy: discard data; pcF<=pendPC; go FETCH.
- IF/ID update, priority order:
  1. flushD=1: validD<=0, instrD<=NOP_INSTR.
  2. stallD=1: hold all fields.
  3. Otherwise: load the delivered instruction (validD<=1, pcD, pcPlus4D=pcD+4), or insert a bubble (validD<=0, instrD<=NOP_INSTR).
- Arithmetic: PC+4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0). PC bits [1:0] are passed through unchecked.
- Throughput and latency:
  - With rdy=1 combinationally, one instruction per cycle.
  - An instruction appears in ID on the edge that completes its transfer.
  - After a redirect in FETCH with rdy=1, the first target instruction reaches ID 2 edges later.
- Simultaneous stallD=1 and flushD=1: flush wins. The skid is still retained unless redir is also high.

Decomposition:
- Shared defines file holds:
  - state encodings: FETCH=2'b00, HOLD=2'b01, DRAIN=2'b10
  - NOP_INSTR
  - default RESET_PC
- One natural sub-module, if_id_reg: a 32+32+32+1-bit register with stall/flush priority and async active-low reset.
- FSM, PC and skid buffer stay in if_stage.

Test Plan:
- Reset release, rdy tied 1, memory returns addr as data → instrD = 0,4,8,C on consecutive edges; validD=1 from edge 1.
- stallD=1 for 3 cycles while fetching addr 8 → req drops after one transfer; IF/ID holds 4; after release instrD=8 then C; no instruction lost or duplicated.
- rdy delayed 3 cycles, pcSrcD=1 pcBranchD=0x100 in wait cycle 1 → DRAIN; old data discarded; next request addr=0x100; validD=0 until 0x100 delivered.
- jumpD=1 pcJumpD=0x40 and pcSrcD=1 pcBranchD=0x80 same cycle → next imem_addr=0x40.
- flushD=1 with stallD=1 → validD=0, instrD=NOP_INSTR; pcF unchanged.
- Start at RESET_PC=32'hFFFF_FFFC → second request addr=0; pcPlus4D=0 for the first instruction. Also assert rst=0 mid-DRAIN → outputs clear immediately and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings,
// default reset PC, bubble instruction word and PC increment helper.
package if_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DRAIN = 2'b10
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // Wraps modulo 2^32; low two bits pass through untouched.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds every field,
// otherwise load a delivered instruction or insert a bubble.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_instr    <= NOP_INSTR;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (load) begin
        id_valid    <= 1'b1;
        id_instr    <= load_instr;
        id_pc       <= load_pc;
        id_pc_plus4 <= pc_plus4(load_pc);
      end else begin
        // Bubble: PC fields keep their last value, only validity matters.
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns pcF, runs the req/rdy handshake to instruction
// memory, parks a fetched word in a skid slot while decode stalls, and
// applies decode-resolved redirects (jump beats branch).
//
// Handshake: imem_req is high only in FETCH and DRAIN and never while rst=0;
// imem_addr (= pcF) is held stable while req=1 and rdy=0; a transfer
// completes on every rising edge that sees req=1 and rdy=1.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcSrcD,
  input  logic [31:0] pcBranchD,
  input  logic        jumpD,
  input  logic [31:0] pcJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic        validD,
  output logic [1:0]  dbg_state
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_f, pc_nxt;
  logic [31:0]  pend_pc, pend_nxt;
  logic [31:0]  skid_instr, skid_pc;
  logic         skid_capture;
  logic         deliver;
  logic [31:0]  deliver_instr, deliver_pc;
  logic         redir;
  logic [31:0]  target;

  assign redir  = jumpD | pcSrcD;
  assign target = jumpD ? pcJumpD : pcBranchD;

  assign imem_req  = rst & ((state == FETCH) | (state == DRAIN));
  assign imem_addr = pc_f;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      pc_f       <= RESET_PC;
      pend_pc    <= 32'h0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
    end else begin
      state   <= state_nxt;
      pc_f    <= pc_nxt;
      pend_pc <= pend_nxt;
      if (skid_capture) begin
        skid_instr <= imem_rdata;
        skid_pc    <= pc_f;
      end
    end
  end

  // The skid slot is occupied exactly when the FSM sits in HOLD.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_f;
    pend_nxt      = pend_pc;
    skid_capture  = 1'b0;
    deliver       = 1'b0;
    deliver_instr = skid_instr;
    deliver_pc    = skid_pc;
    case (state)
      FETCH: begin
        if (imem_rdy) begin
          if (redir) begin
            pc_nxt = target;
          end else begin
            pc_nxt = pc_plus4(pc_f);
            if (stallD) begin
              skid_capture = 1'b1;
              state_nxt    = HOLD;
            end else begin
              deliver       = 1'b1;
              deliver_instr = imem_rdata;
              deliver_pc    = pc_f;
            end
          end
        end else if (redir) begin
          pend_nxt  = target;
          state_nxt = DRAIN;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_nxt    = target;
          state_nxt = FETCH;
        end else if (!stallD) begin
          deliver   = 1'b1;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        // The newest redirect wins, even one arriving with the final rdy.
        if (redir) pend_nxt = target;
        if (imem_rdy) begin
          pc_nxt    = redir ? target : pend_pc;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .stall      (stallD),
    .flush      (flushD),
    .load       (deliver),
    .load_instr (deliver_instr),
    .load_pc    (deliver_pc),
    .id_instr   (instrD),
    .id_pc      (pcD),
    .id_pc_plus4(pcPlus4D),
    .id_valid   (validD)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory echoes the address (xor a key) as
// data; a slot-level model predicts every cycle and literals pin it.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallD, flushD, pcSrcD, jumpD, imem_rdy;
  logic [31:0] pcBranchD, pcJumpD;
  logic        imem_req, validD;
  logic [31:0] imem_addr, imem_rdata, instrD, pcD, pcPlus4D;
  logic [1:0]  dbg_state;
  logic [31:0] key = 32'h0;
  logic        seq_on = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ key;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .stallD    (stallD),
    .flushD    (flushD),
    .pcSrcD    (pcSrcD),
    .pcBranchD (pcBranchD),
    .jumpD     (jumpD),
    .pcJumpD   (pcJumpD),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdy  (imem_rdy),
    .imem_rdata(imem_rdata),
    .instrD    (instrD),
    .pcD       (pcD),
    .pcPlus4D  (pcPlus4D),
    .validD    (validD),
    .dbg_state (dbg_state)
  );

  // ---------------- check helpers ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Slot view: pc = next fetch address, held = a fetched word waiting for
  // decode, drain = a redirect waiting for the outstanding fetch to finish.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    logic [31:0] drain_tgt;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4d;
    logic        held;
    logic        drain;
    logic        valid;
    logic        new_ld;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r        = '0;
    r.pc     = RST_PC;
    r.instr  = NOP;
    return r;
  endfunction

  function automatic model_t model_next(input model_t cur, input logic s, input logic f,
                                        input logic r, input logic b, input logic j,
                                        input logic [31:0] bt, input logic [31:0] jt,
                                        input logic [31:0] k);
    model_t n;
    logic redir, have;
    logic [31:0] tgt, d_instr, d_pc;
    n       = cur;
    redir   = b | j;
    tgt     = j ? jt : bt;
    have    = 1'b0;
    d_instr = '0;
    d_pc    = '0;
    if (cur.held) begin
      if (redir) begin
        n.held = 1'b0;
        n.pc   = tgt;
      end else if (!s) begin
        have    = 1'b1;
        d_instr = cur.held_instr;
        d_pc    = cur.held_pc;
        n.held  = 1'b0;
      end
    end else if (cur.drain) begin
      if (redir) n.drain_tgt = tgt;
      if (r) begin
        n.pc    = n.drain_tgt;
        n.drain = 1'b0;
      end
    end else if (r) begin
      if (redir) n.pc = tgt;
      else if (s) begin
        n.held       = 1'b1;
        n.held_instr = cur.pc ^ k;
        n.held_pc    = cur.pc;
        n.pc         = cur.pc + 32'd4;
      end else begin
        have    = 1'b1;
        d_instr = cur.pc ^ k;
        d_pc    = cur.pc;
        n.pc    = cur.pc + 32'd4;
      end
    end else if (redir) begin
      n.drain     = 1'b1;
      n.drain_tgt = tgt;
    end
    n.new_ld = 1'b0;
    if (f) begin
      n.valid = 1'b0;
      n.instr = NOP;
    end else if (!s) begin
      if (have) begin
        n.valid  = 1'b1;
        n.instr  = d_instr;
        n.pcd    = d_pc;
        n.pc4d   = d_pc + 32'd4;
        n.new_ld = 1'b1;
      end else begin
        n.valid = 1'b0;
        n.instr = NOP;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_reset();
    else m <= model_next(m, stallD, flushD, imem_rdy, pcSrcD, jumpD, pcBranchD, pcJumpD, key);
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      check1("req", imem_req, !m.held);
      if (!m.held) check32("addr", imem_addr, m.pc);
      check1("validD", validD, m.valid);
      check32("instrD", instrD, m.instr);
      if (m.valid) begin
        check32("pcD", pcD, m.pcd);
        check32("pcPlus4D", pcPlus4D, m.pc4d);
      end
      if (seq_on && m.new_ld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL order: got extra instr %h expected none", instrD);
        end else begin
          check32("order", instrD, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic s, input logic f, input logic r, input logic b,
                     input logic j, input logic [31:0] bt, input logic [31:0] jt);
    stallD    = s;
    flushD    = f;
    imem_rdy  = r;
    pcSrcD    = b;
    jumpD     = j;
    pcBranchD = bt;
    pcJumpD   = jt;
    @(posedge clk);
    #2;
  endtask

  task automatic run();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [4:0] vec [16];

  initial begin
    stallD = 0; flushD = 0; pcSrcD = 0; jumpD = 0; imem_rdy = 1;
    pcBranchD = 0; pcJumpD = 0;
    exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h40, 32'h44};
    seq_on = 1'b1;

    #12;
    check1("rst_req", imem_req, 1'b0);
    check1("rst_validD", validD, 1'b0);
    check32("rst_instrD", instrD, NOP);
    check32("rst_pcD", pcD, 32'h0);
    check32("rst_pcPlus4D", pcPlus4D, 32'h0);
    @(negedge clk); #1 rst = 1'b1; #1;
    check1("first_req", imem_req, 1'b1);
    check32("first_addr", imem_addr, RST_PC);

    // Streaming with PC wrap.
    run();
    check32("e1_instr", instrD, 32'hFFFF_FFFC);
    check32("e1_pc4", pcPlus4D, 32'h0);
    check32("wrap_addr", imem_addr, 32'h0);
    check1("e1_valid", validD, 1'b1);
    run(); check32("e2_instr", instrD, 32'h0);
    run(); check32("e3_instr", instrD, 32'h4);

    // Stall three cycles while fetching 8.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check1("stall_req", imem_req, 1'b0);
    check32("stall_state", {30'b0, dbg_state}, 32'h1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check32("stall_hold", instrD, 32'h4);
    run(); check32("unstall_8", instrD, 32'h8); check32("unstall_addr", imem_addr, 32'hC);
    run(); check32("unstall_C", instrD, 32'hC);

    // Redirect while rdy is low -> DRAIN.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    check32("drain_state", {30'b0, dbg_state}, 32'h2);
    check32("drain_addr", imem_addr, 32'h10);
    check1("drain_valid", validD, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    run();
    check32("post_drain_addr", imem_addr, 32'h100);
    check1("post_drain_valid", validD, 1'b0);
    run(); check32("target_100", instrD, 32'h100);

    // Jump beats branch.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 32'h40);
    check32("jump_addr", imem_addr, 32'h40);
    run(); check32("target_40", instrD, 32'h40);

    // Flush with stall, rdy low: pcF must not move.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check1("flush_valid", validD, 1'b0);
    check32("flush_instr", instrD, NOP);
    check32("flush_addr", imem_addr, 32'h44);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    run();
    check32("skid_kept", instrD, 32'h44);
    check32("skid_pc4", pcPlus4D, 32'h48);
    @(negedge clk); #1;
    seq_on = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL order_left: got %0d undelivered expected 0", exp_q.size());
    end

    // Mixed directed vectors {stall, flush, rdy, branch, jump}.
    key = 32'hC0DE_0000;
    vec = '{5'b00100, 5'b10100, 5'b10100, 5'b00010, 5'b00100, 5'b00000,
            5'b00001, 5'b00010, 5'b00100, 5'b00100, 5'b01100, 5'b00000,
            5'b00011, 5'b00110, 5'b00100, 5'b00100};
    for (int i = 0; i < 16; i++)
      cyc(vec[i][4], vec[i][3], vec[i][2], vec[i][1], vec[i][0], 32'h300, 32'h500);

    // Reset in the middle of DRAIN.
    key = 32'h0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h200);
    check32("mid_drain_state", {30'b0, dbg_state}, 32'h2);
    #1 rst = 1'b0; #1;
    check1("arst_req", imem_req, 1'b0);
    check1("arst_valid", validD, 1'b0);
    check32("arst_instr", instrD, NOP);
    check32("arst_pcD", pcD, 32'h0);
    check32("arst_state", {30'b0, dbg_state}, 32'h0);
    stallD = 0; flushD = 0; pcSrcD = 0; jumpD = 0; imem_rdy = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b1; #1;
    check32("restart_addr", imem_addr, RST_PC);
    check1("restart_req", imem_req, 1'b1);
    run(); check32("restart_instr", instrD, RST_PC); check32("restart_pc4", pcPlus4D, 32'h0);
    run(); check32("restart_next", instrD, 32'h0);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
